ksa_mp_seq: RTL and testbench
=============================

// Module: ksa_mp_seq
// PURPOSE
//  Multi-precision add/sub sequencer around one N-bit ksa instance.
//  - Accepts W = N*WORDS bit operands on a valid/ready handshake.
//  - Feeds the adder one N-bit chunk per cycle, LSB chunk first, registering the inter-chunk carry.
//  - Returns the full W-bit result on a second valid/ready handshake.
//  - Trades latency for area where full-width prefix adders are too large.
// PARAMETERS
//  N      4  chunk width = width of the internal ksa instance (>=1)
//  WORDS  4  number of chunks per operation (>=1); W = N*WORDS
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  synchronous reset, active-low
//  in_valid   in   1  operands valid
//  in_ready   out  1  sequencer can accept operands
//  in_a       in   W  operand A
//  in_b       in   W  operand B
//  in_c_in    in   1  carry-in for add; ignored when in_sub=1
//  in_sub     in   1  1: A - B (A + ~B + 1); 0: A + B + c_in
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  out_sum    out  W  result
//  out_c_out  out  1  carry out of bit W-1 (sub: 1 = no borrow)
//  out_ovf    out  1  two's-complement overflow of the W-bit result
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - State -> IDLE; chunk counter, carry reg, out_sum, out_c_out, out_ovf -> 0.
//   - out_valid -> 0, busy -> 0, in_ready -> 1.
//   - Overrides any in-flight operation; the partial result is discarded and no out_valid is produced.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE:
//     - in_ready=1.
//     - On in_valid&in_ready, latch A, B_eff (= in_sub ? ~in_b : in_b) and carry = in_sub ? 1 : in_c_in.
//     - Clear the counter k; go to RUN.
//   - RUN:
//     - in_ready=0.
//     - Cycle k drives the adder with A[k*N+:N], B_eff[k*N+:N] and the carry reg.
//     - Registers the sum into out_sum[k*N+:N] and the adder c_out into the carry reg; k++.
//     - When k==WORDS-1, also register out_c_out and out_ovf; go to DONE.
//   - DONE:
//     - out_valid=1; out_sum, out_c_out and out_ovf held stable until out_ready=1.
//     - On out_valid&out_ready, go to IDLE.
//  Handshakes:
//   - No same-cycle re-accept in DONE; in_ready is a registered-state decode with no combinational path from out_ready.
//   - in_* changes while in_ready=0 are ignored; operands are captured only at acceptance.
//  Latency:
//   - Acceptance at edge t -> out_valid=1 after edge t+WORDS.
//   - Minimum issue interval is WORDS+2 cycles.
//   - WORDS=1: single RUN cycle.
//  Width and overflow:
//   - Adder carry is the only state passed between chunks; out_c_out is the carry out of the last chunk.
//   - out_ovf = (A[W-1]==B_eff[W-1]) && (out_sum[W-1]!=A[W-1]).
//  out_sum upper chunks hold stale or zero data until DONE; consumers sample only when out_valid=1.
// TESTING (N=4, WORDS=4, W=16)
//  - Add wrap: A=0xFFFF, B=0x0001, sub=0, c_in=0
//    -> sum=0x0000, c_out=1, ovf=0; out_valid exactly 4 edges after accept.
//  - Add with carry-in: A=0x1234, B=0x4321, c_in=1 -> sum=0x5556, c_out=0, ovf=0.
//  - Subtract with borrow: A=0x0005, B=0x0007, sub=1, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0.
//  - Overflow: A=0x7FFF, B=0x0001 add -> sum=0x8000, ovf=1.
//    Also A=0x8000, B=0x0001 sub -> sum=0x7FFF, ovf=1.
//  - Backpressure: hold out_ready=0 for 3 cycles in DONE
//    -> out_* stable, in_ready=0, busy=1; on release, in_ready=1 the next cycle.
//    - Toggle in_a during RUN -> result unaffected.
//  - Reset mid-RUN (k=2): rst_n=0 for one edge
//    -> out_valid=0, busy=0, in_ready=1; a new op 0x0001+0x0001 then gives 0x0002.

Source files
------------

// File: rtl/ksa_mp_seq_if.sv
// Operand/result handshake bundle for the multi-precision add/sub sequencer.
// The slave side is the sequencer, the master side is the producer/consumer.
interface ksa_mp_seq_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_c_in;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_c_out;
   logic         out_ovf;
   logic         busy;

   modport slave (
      input  in_valid, in_a, in_b, in_c_in, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_c_out, out_ovf, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_c_in, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_c_out, out_ovf, busy
   );
endinterface

// File: rtl/ksa_mp_seq.sv
// Multi-precision add/sub: one N-bit Kogge-Stone adder reused WORDS times,
// LSB chunk first, with the inter-chunk carry held in a register.
module ksa #(
   parameter int N = 4
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] s_o,
   output logic         c_o
);
   logic [N-1:0] p0, g, p, gn, pn;

   // Carry-in folded into bit 0 generate so g[i] ends as carry out of bit i
   always_comb begin
      p0    = a_i ^ b_i;
      g     = a_i & b_i;
      g[0]  = g[0] | (p0[0] & c_i);
      p     = p0;
      gn    = g;
      pn    = p;
      for (int d = 1; d < N; d = d * 2) begin
         gn = g;
         pn = p;
         for (int i = d; i < N; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      s_o[0] = p0[0] ^ c_i;
      for (int i = 1; i < N; i++) begin
         s_o[i] = p0[i] ^ g[i-1];
      end
      c_o = g[N-1];
   end
endmodule

module ksa_mp_seq #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input logic        clk,
   input logic        rst_n,
   ksa_mp_seq_if.slave bus
);
   localparam int W  = N * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic [KW-1:0] k_q, k_d;
   logic          cy_q, cy_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          amsb_q, amsb_d;
   logic          bmsb_q, bmsb_d;
   logic [N-1:0]  ch_sum;
   logic          ch_cout;
   logic          last;
   logic [W+N-1:0] sh;

   ksa #(.N(N)) u_ksa (
      .a_i (a_q[N-1:0]),
      .b_i (b_q[N-1:0]),
      .c_i (cy_q),
      .s_o (ch_sum),
      .c_o (ch_cout)
   );

   assign last = (k_q == KW'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.out_sum   = sum_q;
      bus.out_c_out = cout_q;
      bus.out_ovf   = ovf_q;
   end

   // Operands shift down one chunk per RUN cycle; results shift in from the top
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      cy_d   = cy_q;
      k_d    = k_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      amsb_d = amsb_q;
      bmsb_d = bmsb_q;
      sh     = {ch_sum, sum_q};
      if (state_q == IDLE && bus.in_valid) begin
         a_d    = bus.in_a;
         b_d    = bus.in_sub ? ~bus.in_b : bus.in_b;
         cy_d   = bus.in_sub | bus.in_c_in;
         k_d    = '0;
         amsb_d = bus.in_a[W-1];
         bmsb_d = bus.in_sub ? ~bus.in_b[W-1] : bus.in_b[W-1];
      end else if (state_q == RUN) begin
         a_d   = a_q >> N;
         b_d   = b_q >> N;
         cy_d  = ch_cout;
         sum_d = sh[W+N-1:N];
         k_d   = k_q + KW'(1);
         if (last) begin
            cout_d = ch_cout;
            ovf_d  = (amsb_q == bmsb_q) && (ch_sum[N-1] != amsb_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         cy_q   <= 1'b0;
         k_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         amsb_q <= 1'b0;
         bmsb_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         cy_q   <= cy_d;
         k_q    <= k_d;
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         amsb_q <= amsb_d;
         bmsb_q <= bmsb_d;
      end
   end
endmodule

// File: tb/tb_ksa_mp_seq.sv
// Directed bench for ksa_mp_seq at N=4, WORDS=4 (16-bit operands).
// Each scenario task drives its stimulus and checks against fixed expectations.
module tb_ksa_mp_seq;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   ksa_mp_seq_if #(.W(16)) bus ();

   ksa_mp_seq #(.N(4), .WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output logic [15:0] s, output logic c,
                        output logic v, output int lat);
      int w;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         tick();
         w++;
      end
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_c_in  = cin;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      s = bus.out_sum;
      c = bus.out_c_out;
      v = bus.out_ovf;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_chk += 6;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
      end
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
      end
      if (bus.out_sum !== 16'h0000) begin
         n_fail++; $display("FAIL rst_sum got=%h exp=0000", bus.out_sum);
      end
      if (bus.out_c_out !== 1'b0) begin
         n_fail++; $display("FAIL rst_cout got=%b exp=0", bus.out_c_out);
      end
      if (bus.out_ovf !== 1'b0) begin
         n_fail++; $display("FAIL rst_ovf got=%b exp=0", bus.out_ovf);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add_wrap();
      logic [15:0] s; logic c, v; int lat;
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
      n_chk += 4;
      if (s !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_sum got=%h exp=0000", s);
      end
      if (c !== 1'b1) begin
         n_fail++; $display("FAIL wrap_cout got=%b exp=1", c);
      end
      if (v !== 1'b0) begin
         n_fail++; $display("FAIL wrap_ovf got=%b exp=0", v);
      end
      if (lat != 4) begin
         n_fail++; $display("FAIL wrap_latency got=%0d exp=4", lat);
      end
   endtask

   task automatic test_add_cin();
      logic [15:0] s; logic c, v; int lat;
      do_op(16'h1234, 16'h4321, 1'b1, 1'b0, s, c, v, lat);
      n_chk += 3;
      if (s !== 16'h5556) begin
         n_fail++; $display("FAIL cin_sum got=%h exp=5556", s);
      end
      if (c !== 1'b0) begin
         n_fail++; $display("FAIL cin_cout got=%b exp=0", c);
      end
      if (v !== 1'b0) begin
         n_fail++; $display("FAIL cin_ovf got=%b exp=0", v);
      end
   endtask

   task automatic test_sub_borrow();
      logic [15:0] s; logic c, v; int lat;
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, v, lat);
      n_chk += 3;
      if (s !== 16'hFFFE) begin
         n_fail++; $display("FAIL sub_sum got=%h exp=fffe", s);
      end
      if (c !== 1'b0) begin
         n_fail++; $display("FAIL sub_cout got=%b exp=0", c);
      end
      if (v !== 1'b0) begin
         n_fail++; $display("FAIL sub_ovf got=%b exp=0", v);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] s; logic c, v; int lat;
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
      n_chk += 3;
      if (s !== 16'h8000) begin
         n_fail++; $display("FAIL ovf_add_sum got=%h exp=8000", s);
      end
      if (c !== 1'b0) begin
         n_fail++; $display("FAIL ovf_add_cout got=%b exp=0", c);
      end
      if (v !== 1'b1) begin
         n_fail++; $display("FAIL ovf_add_ovf got=%b exp=1", v);
      end
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, v, lat);
      n_chk += 3;
      if (s !== 16'h7FFF) begin
         n_fail++; $display("FAIL ovf_sub_sum got=%h exp=7fff", s);
      end
      if (c !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sub_cout got=%b exp=1", c);
      end
      if (v !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sub_ovf got=%b exp=1", v);
      end
   endtask

   task automatic test_backpressure();
      int w;
      bus.in_a     = 16'h0F0F;
      bus.in_b     = 16'h1010;
      bus.in_c_in  = 1'b0;
      bus.in_sub   = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      w = 0;
      while (!bus.out_valid && w < 20) begin
         bus.in_a = 16'hFFFF ^ bus.in_a;
         bus.in_b = 16'h5A5A + 16'(w);
         tick();
         w++;
      end
      n_chk++;
      if (w != 4) begin
         n_fail++; $display("FAIL bp_latency got=%0d exp=4", w);
      end
      for (int i = 0; i < 3; i++) begin
         n_chk += 6;
         if (bus.out_sum !== 16'h1F1F) begin
            n_fail++; $display("FAIL bp_sum[%0d] got=%h exp=1f1f", i, bus.out_sum);
         end
         if (bus.out_c_out !== 1'b0 || bus.out_ovf !== 1'b0) begin
            n_fail++; $display("FAIL bp_flags[%0d] got=%b%b exp=00", i,
                               bus.out_c_out, bus.out_ovf);
         end
         if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus.out_valid);
         end
         if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus.in_ready);
         end
         if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_busy[%0d] got=%b exp=1", i, bus.busy);
         end
         if (bus.out_sum !== 16'h1F1F && i == 2) begin
            n_fail++; $display("FAIL bp_hold got=%h exp=1f1f", bus.out_sum);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_chk += 3;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid);
      end
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL bp_release_busy got=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] s; logic c, v; int lat;
      bus.in_a     = 16'hAAAA;
      bus.in_b     = 16'h5555;
      bus.in_c_in  = 1'b0;
      bus.in_sub   = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_chk += 3;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid);
      end
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_rst_in_ready got=%b exp=1", bus.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ghost[%0d] got=%b exp=0", i, bus.out_valid);
         end
      end
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
      n_chk += 3;
      if (s !== 16'h0002) begin
         n_fail++; $display("FAIL mid_rst_sum got=%h exp=0002", s);
      end
      if (c !== 1'b0 || v !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_flags got=%b%b exp=00", c, v);
      end
      if (lat != 4) begin
         n_fail++; $display("FAIL mid_rst_latency got=%0d exp=4", lat);
      end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      bus.in_a      = 16'h0102;
      bus.in_b      = 16'h0304;
      bus.in_c_in   = 1'b0;
      bus.in_sub    = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.in_ready) acc.push_back(i);
         if (bus.out_valid) begin
            n_chk += 2;
            if (bus.out_sum !== 16'h0406) begin
               n_fail++; $display("FAIL b2b_sum[%0d] got=%h exp=0406", i, bus.out_sum);
            end
            if (bus.in_ready !== 1'b0) begin
               n_fail++; $display("FAIL b2b_reaccept[%0d] got=%b exp=0", i, bus.in_ready);
            end
         end
         tick();
      end
      bus.in_valid = 1'b0;
      n_chk++;
      if (acc.size() < 3) begin
         n_fail++; $display("FAIL b2b_accepts got=%0d exp>=3", acc.size());
      end else begin
         n_chk++;
         if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
            n_fail++; $display("FAIL b2b_interval got=%0d,%0d exp=6,6",
                               acc[1] - acc[0], acc[2] - acc[1]);
         end
      end
      for (int i = 0; i < 8; i++) tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c_in   = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_add_wrap();
      test_add_cin();
      test_sub_borrow();
      test_overflow();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
